// File: rtl/ps2_scancode_translator_pkg.sv
// ---------------------------------------------------------------------------
// ps2_scancode_translator_pkg
//   Shared types and constants for the PS/2 Set-2 to ASCII/VT100 translator.
//   - Scancode_t / UartFifoData_t : byte types on the keyboard and FIFO sides
//   - KeySeq_t                    : a translated key, up to MaxSeqLen bytes
//   - TranslatorState_t           : control FSM states
//   - csi_seq / is_ignored_code   : small helpers used by the keymap and top
// ---------------------------------------------------------------------------
package ps2_scancode_translator_pkg;

    // Longest sequence a single key press can produce (ESC [ 3 ~).
    localparam int MaxSeqLen = 4;
    localparam int SeqIdxW   = $clog2(MaxSeqLen);

    typedef logic [7:0] Scancode_t;
    typedef logic [7:0] UartFifoData_t;

    localparam Scancode_t     SC_EXTENDED = 8'hE0;
    localparam Scancode_t     SC_BREAK    = 8'hF0;
    localparam Scancode_t     SC_PAUSE    = 8'hE1;
    localparam UartFifoData_t ASCII_ESC   = 8'h1B;

    localparam Scancode_t SC_LSHIFT = 8'h12;
    localparam Scancode_t SC_RSHIFT = 8'h59;
    localparam Scancode_t SC_CTRL   = 8'h14;
    localparam Scancode_t SC_CAPS   = 8'h58;

    // bytes[0] is transmitted first; only the first len entries are valid.
    typedef struct packed {
        logic [2:0]                     len;
        logic [MaxSeqLen-1:0][7:0]      bytes;
    } KeySeq_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EMIT
    } TranslatorState_t;

    // Builds an ESC '[' p1 [p2] control sequence of the given length.
    function automatic KeySeq_t csi_seq(input UartFifoData_t p1,
                                        input UartFifoData_t p2,
                                        input logic [2:0]    len);
        KeySeq_t s;
        s          = '0;
        s.len      = len;
        s.bytes[0] = ASCII_ESC;
        s.bytes[1] = 8'h5B;
        s.bytes[2] = p1;
        s.bytes[3] = p2;
        return s;
    endfunction

    // Keyboard status/response bytes that carry no key information.
    function automatic logic is_ignored_code(input Scancode_t sc);
        return sc inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    endfunction

endpackage

// File: rtl/ps2_keymap.sv
// ---------------------------------------------------------------------------
// ps2_keymap
//   Purely combinational Set-2 keymap. Maps one make code plus the current
//   modifier state onto the byte sequence the terminal expects.
//   Ports:
//     scancode  in   make code (prefixes already stripped)
//     extended  in   code was preceded by E0
//     shift     in   a shift key is held
//     caps      in   caps lock is active
//     ctrl      in   a ctrl key is held
//     seq       out  translated sequence; len == 0 means "no output"
// ---------------------------------------------------------------------------
module ps2_keymap
    import ps2_scancode_translator_pkg::*;
(
    input  Scancode_t scancode,
    input  logic      extended,
    input  logic      shift,
    input  logic      caps,
    input  logic      ctrl,
    output KeySeq_t   seq
);

    UartFifoData_t lower;
    UartFifoData_t upper;
    UartFifoData_t ch;
    logic          is_letter;

    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // through the case statements can leave one unassigned and infer a latch.
        seq       = '0;
        lower     = '0;
        upper     = '0;
        ch        = '0;
        is_letter = 1'b0;

        if (extended) begin
            case (scancode)
                8'h75:   seq = csi_seq(8'h41, 8'h00, 3'd3); // up
                8'h72:   seq = csi_seq(8'h42, 8'h00, 3'd3); // down
                8'h74:   seq = csi_seq(8'h43, 8'h00, 3'd3); // right
                8'h6B:   seq = csi_seq(8'h44, 8'h00, 3'd3); // left
                8'h71:   seq = csi_seq(8'h33, 8'h7E, 3'd4); // delete
                default: seq = '0;
            endcase
        end else begin
            // Letters only set 'lower'; their upper case is derived below.
            case (scancode)
                8'h1C: lower = "a";
                8'h32: lower = "b";
                8'h21: lower = "c";
                8'h23: lower = "d";
                8'h24: lower = "e";
                8'h2B: lower = "f";
                8'h34: lower = "g";
                8'h33: lower = "h";
                8'h43: lower = "i";
                8'h3B: lower = "j";
                8'h42: lower = "k";
                8'h4B: lower = "l";
                8'h3A: lower = "m";
                8'h31: lower = "n";
                8'h44: lower = "o";
                8'h4D: lower = "p";
                8'h15: lower = "q";
                8'h2D: lower = "r";
                8'h1B: lower = "s";
                8'h2C: lower = "t";
                8'h3C: lower = "u";
                8'h2A: lower = "v";
                8'h1D: lower = "w";
                8'h22: lower = "x";
                8'h35: lower = "y";
                8'h1A: lower = "z";
                8'h16: begin lower = "1";   upper = "!";   end
                8'h1E: begin lower = "2";   upper = "@";   end
                8'h26: begin lower = "3";   upper = "#";   end
                8'h25: begin lower = "4";   upper = "$";   end
                8'h2E: begin lower = "5";   upper = "%";   end
                8'h36: begin lower = "6";   upper = "^";   end
                8'h3D: begin lower = "7";   upper = "&";   end
                8'h3E: begin lower = "8";   upper = "*";   end
                8'h46: begin lower = "9";   upper = "(";   end
                8'h45: begin lower = "0";   upper = ")";   end
                8'h0E: begin lower = 8'h60; upper = 8'h7E; end // ` ~
                8'h4E: begin lower = "-";   upper = "_";   end
                8'h55: begin lower = "=";   upper = "+";   end
                8'h54: begin lower = "[";   upper = "{";   end
                8'h5B: begin lower = "]";   upper = "}";   end
                8'h5D: begin lower = 8'h5C; upper = 8'h7C; end // \ |
                8'h4C: begin lower = ";";   upper = ":";   end
                8'h52: begin lower = 8'h27; upper = 8'h22; end // ' "
                8'h41: begin lower = ",";   upper = "<";   end
                8'h49: begin lower = ".";   upper = ">";   end
                8'h4A: begin lower = "/";   upper = "?";   end
                8'h29: begin lower = 8'h20; upper = 8'h20; end // space
                8'h5A: begin lower = 8'h0D; upper = 8'h0D; end // enter
                8'h66: begin lower = 8'h7F; upper = 8'h7F; end // backspace
                8'h0D: begin lower = 8'h09; upper = 8'h09; end // tab
                8'h76: begin lower = 8'h1B; upper = 8'h1B; end // escape
                default: begin lower = '0; upper = '0; end
            endcase

            is_letter = (lower >= "a") && (lower <= "z");

            // Caps lock only flips letters; ctrl folds a letter to its control code.
            if (is_letter) begin
                upper = lower ^ 8'h20;
                if (ctrl)
                    ch = lower & 8'h1F;
                else
                    ch = (shift ^ caps) ? upper : lower;
            end else begin
                ch = shift ? upper : lower;
            end

            if (lower != '0) begin
                seq.len      = 3'd1;
                seq.bytes[0] = ch;
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_translator.sv
// ---------------------------------------------------------------------------
// ps2_scancode_translator
//   Turns PS/2 Set-2 scancode bytes into ASCII/VT100 bytes for the UART TX
//   FIFO. Tracks E0/F0/E1 prefixes and shift/ctrl/caps state; each key press
//   yields 0..MaxSeqLen bytes, written back-to-back unless the FIFO is full.
//   Ports:
//     clk               in   system clock
//     rst               in   asynchronous active-high reset
//     scancodeDone      in   one-cycle strobe, scancode valid
//     scancode          in   received scancode byte
//     fifoFull          in   TX FIFO cannot accept a byte this cycle
//     fifoWriteRequest  out  a byte is written in every cycle this is high
//     fifoInData        out  byte being written
//     scancodeDropped   out  pulses when an incoming byte is discarded
// ---------------------------------------------------------------------------
module ps2_scancode_translator
    import ps2_scancode_translator_pkg::*;
#(
    parameter int PauseSkipLen = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scancodeDone,
    input  Scancode_t     scancode,
    input  logic          fifoFull,
    output logic          fifoWriteRequest,
    output UartFifoData_t fifoInData,
    output logic          scancodeDropped
);

    localparam int SkipW = $clog2(PauseSkipLen + 1);

    TranslatorState_t   state, state_next;

    Scancode_t          cur_code;
    logic               ext_flag;
    logic               rel_flag;
    logic               shift_on;
    logic               ctrl_on;
    logic               caps_on;
    logic               caps_held;
    logic [SkipW-1:0]   skip_cnt;

    KeySeq_t            key_seq;
    KeySeq_t            seq_buf;
    logic [SeqIdxW-1:0] seq_idx;

    // One-entry holding slot for bytes that arrive while busy.
    logic               pend_valid;
    Scancode_t          pend_code;

    // Classification of the byte being decoded.
    logic in_skip;
    logic is_prefix;
    logic is_ignored;
    logic is_make;
    logic is_shift;
    logic is_ctrl;
    logic is_caps;
    logic emit_hit;
    logic last_byte;

    ps2_keymap u_keymap (
        .scancode (cur_code),
        .extended (ext_flag),
        .shift    (shift_on),
        .caps     (caps_on),
        .ctrl     (ctrl_on),
        .seq      (key_seq)
    );

    assign in_skip    = (skip_cnt != '0);
    assign is_prefix  = cur_code inside {SC_PAUSE, SC_EXTENDED, SC_BREAK};
    assign is_ignored = is_ignored_code(cur_code);
    assign is_make    = !rel_flag;
    // E0 12 / E0 59 are fake shifts inside extended sequences, so only the
    // plain codes count; ctrl is honoured with or without E0 (right ctrl).
    assign is_shift   = !ext_flag && (cur_code == SC_LSHIFT || cur_code == SC_RSHIFT);
    assign is_ctrl    = (cur_code == SC_CTRL);
    assign is_caps    = !ext_flag && (cur_code == SC_CAPS);

    assign emit_hit   = !in_skip && !is_prefix && !is_ignored && !is_shift &&
                        !is_ctrl && !is_caps && is_make && (key_seq.len != '0);

    assign last_byte  = (3'(seq_idx) == (seq_buf.len - 3'd1));

    // A byte is lost whenever the holding slot is already occupied, which
    // includes a strobe in IDLE while IDLE is consuming the held byte.
    assign scancodeDropped = scancodeDone && pend_valid;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is updated only with non-blocking
        // assignments so every register samples pre-edge values.
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next       = state;
        fifoWriteRequest = 1'b0;
        fifoInData       = '0;
        case (state)
            ST_IDLE: begin
                if (pend_valid || scancodeDone)
                    state_next = ST_DECODE;
            end
            ST_DECODE: begin
                state_next = emit_hit ? ST_EMIT : ST_IDLE;
            end
            ST_EMIT: begin
                // Data is presented even while full so it stays stable.
                fifoInData = seq_buf.bytes[seq_idx];
                if (!fifoFull) begin
                    fifoWriteRequest = 1'b1;
                    if (last_byte)
                        state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_code   <= '0;
            ext_flag   <= 1'b0;
            rel_flag   <= 1'b0;
            shift_on   <= 1'b0;
            ctrl_on    <= 1'b0;
            caps_on    <= 1'b0;
            caps_held  <= 1'b0;
            skip_cnt   <= '0;
            // NOTE: the sequence buffer is cleared with the control state so
            // a reset mid-emission can never replay stale bytes.
            seq_buf    <= '0;
            seq_idx    <= '0;
            pend_valid <= 1'b0;
            pend_code  <= '0;
        end else begin
            if (state != ST_IDLE && scancodeDone && !pend_valid) begin
                pend_valid <= 1'b1;
                pend_code  <= scancode;
            end

            case (state)
                ST_IDLE: begin
                    if (pend_valid) begin
                        cur_code   <= pend_code;
                        pend_valid <= 1'b0;
                    end else if (scancodeDone) begin
                        cur_code <= scancode;
                    end
                end

                ST_DECODE: begin
                    if (in_skip) begin
                        skip_cnt <= skip_cnt - 1'b1;
                    end else if (cur_code == SC_PAUSE) begin
                        skip_cnt <= SkipW'(PauseSkipLen);
                    end else if (cur_code == SC_EXTENDED) begin
                        ext_flag <= 1'b1;
                    end else if (cur_code == SC_BREAK) begin
                        rel_flag <= 1'b1;
                    end else begin
                        ext_flag <= 1'b0;
                        rel_flag <= 1'b0;
                        if (!is_ignored) begin
                            if (is_shift) begin
                                shift_on <= is_make;
                            end else if (is_ctrl) begin
                                ctrl_on <= is_make;
                            end else if (is_caps) begin
                                // Typematic repeats of caps must not re-toggle.
                                if (is_make && !caps_held)
                                    caps_on <= !caps_on;
                                caps_held <= is_make;
                            end else if (emit_hit) begin
                                seq_buf <= key_seq;
                                seq_idx <= '0;
                            end
                        end
                    end
                end

                ST_EMIT: begin
                    if (!fifoFull)
                        seq_idx <= last_byte ? '0 : seq_idx + 1'b1;
                end

                default: ;
            endcase
        end
    end

endmodule

// File: doc/ps2_scancode_translator.md
Name: ps2_scancode_translator

Overview:
Converts PS/2 Set-2 scancode bytes from the keyboard receiver into ASCII/VT100 byte sequences for the terminal. Results are pushed into the 8-bit UART TX FIFO, which the FIFO consumer drains to the UART transmitter.
Tracks prefix state (E0, F0, E1) and modifier state (shift, ctrl, caps lock).
Emits 1–4 bytes per key press. Emission stalls on FIFO full.

Parameters:
MaxSeqLen, 4, maximum bytes emitted per key event (sequence buffer depth)
PauseSkipLen, 7, bytes discarded after an E1 (Pause) prefix

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
scancodeDone  input  1  one-cycle strobe; scancode valid
scancode  input  8  received scancode byte (Scancode_t)
fifoFull  input  1  TX FIFO full
fifoWriteRequest  output  1  FIFO write strobe; a byte is written in every cycle this is high
fifoInData  output  8  byte to write (UartFifoData_t)
scancodeDropped  output  1  one-cycle pulse when an incoming scancode is discarded due to overflow

Behaviour:
- Reset: all outputs 0. State cleared: prefix flags, modifiers, caps, skip counter, sequence buffer, pending register. Reset mid-emission aborts the sequence; no further writes.
- States: IDLE, DECODE, EMIT.
- IDLE:
  - Takes a byte from the pending register if it is valid, else from a scancodeDone strobe.
  - Latches the byte and moves to DECODE.
- DECODE (1 cycle, registered keymap lookup), in priority order:
  - Skip counter nonzero: decrement; no output.
  - E1: load skip counter with PauseSkipLen.
  - E0: set extended.
  - F0: set release.
  - AA/FA/FE/EE/00/FF: ignored; clear prefixes.
  - Modifiers update on make/break: 12 and 59 set/clear shift; 14 and E0 14 set/clear ctrl.
  - 58 make toggles caps only if capsHeld is clear, then sets capsHeld. 58 break clears capsHeld.
  - Any other make: looked up in ps2_keymap. Non-empty result loads the sequence buffer and enters EMIT; empty result returns to IDLE.
  - Any break: no output.
  - All non-prefix bytes clear the extended and release flags.
- Character rules:
  - Letters: the effective shift is shift XOR caps. Non-letters use shift only.
  - ctrl with a letter emits (lowercase code & 8'h1F).
  - Enter 5A → 0D. Backspace 66 → 7F. Tab 0D → 09. Esc 76 → 1B.
  - E0 75/72/74/6B → 1B 5B 41/42/43/44.
  - E0 71 → 1B 5B 33 7E.
- EMIT:
  - fifoWriteRequest = EMIT && !fifoFull.
  - fifoInData = buffer[idx]. idx increments on each write.
  - After the write of byte len-1, return to IDLE.
  - While fifoFull, hold with no write; the data stays stable.
- Latency: a strobe in cycle N (IDLE, no pending) gives the first write in cycle N+2 if the FIFO is not full. Consecutive bytes are written back-to-back.
- Scancodes arriving outside IDLE go to a one-entry pending register.
  - If pending is already valid, the new byte is discarded and scancodeDropped pulses.
  - In IDLE, a strobe coinciding with a valid pending byte is likewise discarded with a pulse.
- FIFO full at EMIT entry: no write until not full. No byte is ever lost or duplicated.

Decomposition:
- DataType package gets these items:
  - constants SC_EXTENDED=8'hE0, SC_BREAK=8'hF0, SC_PAUSE=8'hE1, ASCII_ESC=8'h1B
  - KeySeq_t struct: len (3 bits), bytes[MaxSeqLen] of 8 bits
  - a TranslatorState_t enum
- Sub-module ps2_keymap: purely combinational. Inputs are scancode, extended, shift, caps and ctrl; the output is a KeySeq_t. It holds the full lookup table, and its output is registered in the parent.

Test Plan:
- Strobes 1C; later F0, 1C → exactly one write, 61; no write on the break.
- 12, 1C, F0 1C, F0 12, 1C → writes 41 then 61.
- 58, F0 58, 1C; then 12, 1C → 41, then 61 (caps XOR shift).
- 14, 21 → 03. E0 75 → 1B 5B 41 on consecutive cycles. E0 71 → 1B 5B 33 7E.
- fifoFull held high for 10 cycles during E0 74 → fifoInData stable at 1B, no write. Release → 1B 5B 43, each written once.
- During EMIT, strobe 1C then 32 → 32 dropped (scancodeDropped pulse). 1C then yields 61 after the current sequence.
- E1 14 77 E1 F0 14 F0 77 followed by 1C → only 61 emitted.
- rst asserted after the first byte of an arrow sequence → no further writes. Outputs are 0 and modifiers cleared: a following 1C gives 61.
